// File: rtl/ecg_beat_detector.sv
// ECG R-peak detector: threshold arm, local-maximum search, refractory blanking, R-R interval and asystole watchdog.
// Defining ECG_BEAT_RR_AVG_EN adds a registered average of the last four R-R intervals on rr_avg.
module ecg_beat_detector #(
    parameter logic signed [11:0] THRESH  = 12'sd768,
    parameter int unsigned        REFRACT = 16,
    parameter int unsigned        MAX_RR  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    output logic        beat_pulse,
    output logic [11:0] peak_value,
    output logic [15:0] rr_interval,
    output logic        rr_valid,
    output logic        asystole,
    output logic [15:0] rr_avg
);
    localparam logic [15:0] MAX_RR_C  = 16'(MAX_RR);
    localparam logic [15:0] REFRACT_C = 16'(REFRACT);

    typedef enum logic [1:0] {S_SEARCH, S_RISING, S_REFRACT} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v >= MAX_RR_C) ? MAX_RR_C : v + 16'd1;
    endfunction

    state_t             state_q;
    logic signed [11:0] max_q;
    logic signed [11:0] peak_q;
    logic [15:0]        cnt_q;
    logic [15:0]        since_q;
    logic [15:0]        cand_q;
    logic [15:0]        ref_q;
    logic [15:0]        rr_q;
    logic               first_q;
    logic               beat_q;
    logic               rrv_q;
    logic               asys_q;

    logic signed [11:0] sample_s;
    logic [15:0]        cnt_d;
    logic [15:0]        since_d;
    logic               asys_entry;

    assign sample_s = $signed(sample);
    assign cnt_d    = sat_inc(cnt_q);
    assign since_d  = sat_inc(since_q);
    // Asystole is an event on the counter reaching the limit, not a level, so a saturated counter
    // does not keep forcing the FSM back to SEARCH and the next beat can still be found.
    assign asys_entry = sample_valid && (cnt_q < MAX_RR_C) && (cnt_d == MAX_RR_C);

    // cnt_q: valid samples since the last peak sample; since_q: valid samples since the current max;
    // cand_q: distance from the last peak to the current max, reported as the interval when declared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_SEARCH;
            max_q   <= '0;
            peak_q  <= '0;
            cnt_q   <= '0;
            since_q <= '0;
            cand_q  <= '0;
            ref_q   <= '0;
            rr_q    <= '0;
            first_q <= 1'b1;
            beat_q  <= 1'b0;
            rrv_q   <= 1'b0;
            asys_q  <= 1'b0;
        end else begin
            beat_q <= 1'b0;
            rrv_q  <= 1'b0;
            if (sample_valid) begin
                cnt_q <= cnt_d;
                if (asys_entry) begin
                    state_q <= S_SEARCH;
                    first_q <= 1'b1;
                    asys_q  <= 1'b1;
                end else begin
                    case (state_q)
                        S_SEARCH: begin
                            if (sample_s >= THRESH) begin
                                state_q <= S_RISING;
                                max_q   <= sample_s;
                                cand_q  <= cnt_d;
                                since_q <= '0;
                            end
                        end
                        S_RISING: begin
                            if (sample_s > max_q) begin
                                max_q   <= sample_s;
                                cand_q  <= cnt_d;
                                since_q <= '0;
                            end else if (sample_s == max_q) begin
                                since_q <= since_d;
                            end else begin
                                beat_q  <= 1'b1;
                                peak_q  <= max_q;
                                asys_q  <= 1'b0;
                                first_q <= 1'b0;
                                if (!first_q) begin
                                    rr_q  <= cand_q;
                                    rrv_q <= 1'b1;
                                end
                                cnt_q   <= since_d;
                                ref_q   <= '0;
                                state_q <= (REFRACT == 0) ? S_SEARCH : S_REFRACT;
                            end
                        end
                        S_REFRACT: begin
                            if (ref_q >= REFRACT_C - 16'd1) begin
                                state_q <= S_SEARCH;
                            end else begin
                                ref_q <= ref_q + 16'd1;
                            end
                        end
                        default: state_q <= S_SEARCH;
                    endcase
                end
            end
        end
    end

    assign beat_pulse  = beat_q;
    assign peak_value  = peak_q;
    assign rr_interval = rr_q;
    assign rr_valid    = rrv_q;
    assign asystole    = asys_q;

`ifdef ECG_BEAT_RR_AVG_EN
    logic [15:0] hist_q [4];
    logic [2:0]  fill_q;
    logic [15:0] avg_q;

    function automatic logic [15:0] avg4(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d);
        logic [17:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return sum[17:2];
    endfunction

    // The average stays zero until four real intervals are held, so it never mixes in cleared entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            fill_q <= '0;
            avg_q  <= '0;
        end else if (asys_entry) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            fill_q <= '0;
            avg_q  <= '0;
        end else if (rrv_q) begin
            hist_q[0] <= rr_q;
            hist_q[1] <= hist_q[0];
            hist_q[2] <= hist_q[1];
            hist_q[3] <= hist_q[2];
            if (fill_q < 3'd4) fill_q <= fill_q + 3'd1;
            if (fill_q >= 3'd3) avg_q <= avg4(rr_q, hist_q[0], hist_q[1], hist_q[2]);
        end
    end

    assign rr_avg = avg_q;
`else
    assign rr_avg = 16'd0;
`endif

endmodule
